// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-cycle integer divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    function automatic logic is_signed(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step: shift R:Q left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_sub;
    logic             w_ge;

    assign w_shift = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_sub   = {1'b0, w_shift} - {2'b00, i_div};
    // A set R MSB means the shifted value already exceeds any divisor.
    assign w_ge    = ~w_sub[WIDTH+1] | i_r[WIDTH];

    assign o_r = w_ge ? w_sub[WIDTH:0] : w_shift;
    assign o_q = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/int_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with valid/ready on both sides.
module int_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_dbz
);

    div_state_e       r_state, w_next_state;
    div_op_e          r_op;
    logic             r_sign_a, r_sign_b;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo, r_div, r_result;
    logic             r_dbz;
    logic [CNT_W-1:0] r_cnt;

    div_op_e          w_op;
    logic             w_sgn_op, w_neg_a, w_neg_b, w_dbz, w_ovf, w_last;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_fix_q, w_fix_r, w_final;
    logic [WIDTH:0]   w_step_r;
    logic [WIDTH-1:0] w_step_q;

    assign w_op     = div_op_e'(in_op);
    assign w_sgn_op = is_signed(w_op);
    assign w_neg_a  = w_sgn_op & in_a[WIDTH-1];
    assign w_neg_b  = w_sgn_op & in_b[WIDTH-1];
    assign w_abs_a  = w_neg_a ? -in_a : in_a;
    assign w_abs_b  = w_neg_b ? -in_b : in_b;
    assign w_dbz    = (in_b == '0);
    assign w_ovf    = w_sgn_op && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_r   (r_rem),
        .i_q   (r_quo),
        .i_div (r_div),
        .o_r   (w_step_r),
        .o_q   (w_step_q)
    );

    // Sign fix-up applies to the values produced by the final step.
    assign w_fix_q = (r_op == DIV && (r_sign_a ^ r_sign_b)) ? -w_step_q : w_step_q;
    assign w_fix_r = (r_op == REM && r_sign_a) ? -w_step_r[WIDTH-1:0] : w_step_r[WIDTH-1:0];
    assign w_final = r_op[1] ? w_fix_r : w_fix_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = (w_dbz || w_ovf) ? DONE : CALC;
            CALC:    if (w_last) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= DIV;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op     <= w_op;
                    r_sign_a <= w_neg_a;
                    r_sign_b <= w_neg_b;
                    r_rem    <= '0;
                    r_quo    <= w_abs_a;
                    r_div    <= w_abs_b;
                    r_cnt    <= '0;
                    r_dbz    <= w_dbz;
                    if (w_dbz)      r_result <= in_op[1] ? in_a : '1;
                    else if (w_ovf) r_result <= in_op[1] ? '0 : in_a;
                end
                CALC: begin
                    r_rem <= w_step_r;
                    r_quo <= w_step_q;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
    assign out_dbz    = r_dbz;

endmodule

// File: tb/tb_int_div_unit.sv
// Scoreboard bench for int_div_unit: directed corner cases plus randomized ops vs an arithmetic model.
module tb_int_div_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [1:0]   in_op = '0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid, out_dbz;
    logic [W-1:0] out_result;

    int_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dbz    (out_dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    bit           rand_ready = 0;
    bit           seen = 0;
    logic [W-1:0] held;
    int           acc_cyc;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, q, r;
        bit     sgn;
        sgn   = (op == OP_DIV) || (op == OP_REM);
        e.acc = 0;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.res = op[1] ? a : '1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = (op == OP_DIV) ? a : '0;
            e.lat = 1;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q = sa / sb;
            r = sa % sb;
            e.res = op[1] ? r[W-1:0] : q[W-1:0];
            e.lat = W + 1;
        end
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        int   guard;
        exp_t e;
        guard = 0;
        while (in_ready !== 1'b1) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
            if (guard > 2000) begin
                checks++; errors++;
                $display("FAIL issue_timeout: in_ready never rose within %0d cycles", guard);
                return;
            end
        end
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        if (push) begin
            e     = model(op, a, b);
            e.acc = acc_cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 || in_ready !== 1'b1) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
            if (guard > 5000) begin
                checks++; errors++;
                $display("FAIL drain_timeout: %0d results still pending", sb_q.size());
                return;
            end
        end
    endtask

    // Monitor: pop on the first cycle a result is presented, then verify it stays stable.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1;
                held = out_result;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got %h expected none", out_result);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", out_result, e.res);
                    chk("dbz", W'(out_dbz), W'(e.dbz));
                    chk("latency", W'(cyc - e.acc + 1), W'(e.lat));
                end
            end else begin
                chk("held_result", out_result, held);
                chk("in_ready_in_done", W'(in_ready), W'(0));
            end
        end else begin
            seen = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [1:0]   op;
        logic [W-1:0] a, b;

        #2;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_result", out_result, '0);
        chk("rst_out_dbz", W'(out_dbz), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(OP_DIVU, 32'd100, 32'd7, 1);
        issue(OP_REMU, 32'd100, 32'd7, 1);
        issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1);
        issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 1);
        issue(OP_REM,  32'd7, 32'hFFFF_FFFE, 1);
        issue(OP_DIVU, 32'd5, 32'd0, 1);
        issue(OP_REM,  32'd5, 32'd0, 1);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1);
        drain();

        // Back-pressure: result must sit in DONE untouched.
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd1000, 32'd7, 1);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("bp_valid_reached", W'(out_valid), W'(1));
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("bp_out_valid", W'(out_valid), W'(1));
        chk("bp_in_ready", W'(in_ready), W'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", W'(in_ready), W'(1));
        chk("bp_release_out_valid", W'(out_valid), W'(0));

        // Reset in the middle of CALC discards the operation.
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'd13, 0);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_out_result", out_result, '0);
        chk("abort_out_dbz", W'(out_dbz), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(OP_DIVU, 32'd9, 32'd3, 1);
        drain();

        // Randomized ops with random consumer back-pressure.
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(0, 1000));
                2:       a = -32'($urandom_range(1, 1000));
                default: a = 32'h8000_0000;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            issue(op, a, b, 1);
        end
        drain();
        rand_ready = 0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
